// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO posted-write buffer.
package mmio_pkg;

  localparam logic [7:0] MMIO_STATUS     = 8'hF0;
  localparam logic [7:0] MMIO_MBOX       = 8'hF4;
  localparam logic [7:0] MMIO_CTRL       = 8'hF8;
  localparam logic [7:0] MMIO_DATA_LIMIT = 8'hF0;

  localparam int unsigned STAT_OVF_BIT   = 31;
  localparam int unsigned STAT_MBOX_BIT  = 30;
  localparam int unsigned STAT_CNT_LSB   = 4;
  localparam int unsigned STAT_FULL_BIT  = 3;
  localparam int unsigned STAT_EMPTY_BIT = 2;

  typedef struct packed {
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } mmio_entry_t;

  function automatic logic [31:0] status_word(input logic       ovf,
                                              input logic       mbox_valid,
                                              input logic       full,
                                              input logic       empty,
                                              input logic [3:0] count);
    logic [31:0] w;
    w                              = '0;
    w[STAT_OVF_BIT]                = ovf;
    w[STAT_MBOX_BIT]               = mbox_valid;
    w[STAT_CNT_LSB+3:STAT_CNT_LSB] = count;
    w[STAT_FULL_BIT]               = full;
    w[STAT_EMPTY_BIT]              = empty;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter  int unsigned WIDTH = 44,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iPushData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oHeadData,
  output logic             oFull,
  output logic             oEmpty,
  output logic [CNT_W-1:0] oCount,
  output logic             oDrop
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = iPop & ~w_empty;
  assign w_push_ok = iPush & (~w_full | w_pop_ok);

  assign oFull   = w_full;
  assign oEmpty  = w_empty;
  assign oCount  = r_count;
  assign oDrop   = iPush & w_full & ~w_pop_ok;
  // Masked when empty so the head reads as zero after reset and after draining.
  assign oHeadData = w_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge iCLK) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= iPushData;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_write_buffer.sv
// MMIO window decoder that posts CPU stores into a FIFO drained over a valid/ready bus,
// with a status register, response mailbox and sticky overflow flag.
module mmio_write_buffer
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFF00_0000,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PADDR_W   = 8
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iReadEnable,
  input  logic               iWriteEnable,
  input  logic [3:0]         iByteEnable,
  input  logic [31:0]        iAddress,
  input  logic [31:0]        iWriteData,
  output logic               oHit,
  output logic [31:0]        oReadData,
  output logic               oPValid,
  input  logic               iPReady,
  output logic [PADDR_W-1:0] oPAddr,
  output logic [31:0]        oPData,
  output logic [3:0]         oPByteEn,
  input  logic               iPRspValid,
  input  logic [31:0]        iPRspData,
  output logic               oOverflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             w_hit;
  logic [7:0]       w_off;
  logic             w_push_req;
  logic             w_pop;
  logic             w_ctrl_clr;
  logic             w_mbox_rd;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic [CNT_W-1:0] w_count;
  mmio_entry_t      w_entry;
  mmio_entry_t      w_head;

  logic             r_overflow;
  logic             r_mbox_valid;
  logic [31:0]      r_mbox_data;

  assign w_hit      = (iAddress[31:8] == BASE_ADDR[31:8]);
  assign w_off      = iAddress[7:0];
  assign w_push_req = iWriteEnable & w_hit & (w_off < MMIO_DATA_LIMIT);
  assign w_pop      = oPValid & iPReady;
  assign w_ctrl_clr = iWriteEnable & w_hit & (w_off == MMIO_CTRL) & iByteEnable[3] & iWriteData[31];
  assign w_mbox_rd  = iReadEnable & w_hit & (w_off == MMIO_MBOX);

  assign w_entry.addr = w_off;
  assign w_entry.be   = iByteEnable;
  assign w_entry.data = iWriteData;

  sync_fifo #(
    .WIDTH($bits(mmio_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iPush     (w_push_req),
    .iPushData (w_entry),
    .iPop      (w_pop),
    .oHeadData (w_head),
    .oFull     (w_full),
    .oEmpty    (w_empty),
    .oCount    (w_count),
    .oDrop     (w_drop)
  );

  assign oHit      = w_hit;
  assign oPValid   = ~w_empty;
  assign oPAddr    = PADDR_W'(w_head.addr);
  assign oPData    = w_head.data;
  assign oPByteEn  = w_head.be;
  assign oOverflow = r_overflow;

  // A drop in the same cycle as a CTRL clear keeps the flag set.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (w_ctrl_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // A response arriving during a MBOX read wins over the read clear.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_mbox_valid <= 1'b0;
      r_mbox_data  <= '0;
    end else if (iPRspValid) begin
      r_mbox_valid <= 1'b1;
      r_mbox_data  <= iPRspData;
    end else if (w_mbox_rd) begin
      r_mbox_valid <= 1'b0;
    end
  end

  always_comb begin
    oReadData = '0;
    if (w_hit) begin
      unique case (w_off)
        MMIO_STATUS: oReadData = status_word(r_overflow, r_mbox_valid, w_full, w_empty,
                                             4'(w_count));
        MMIO_MBOX:   oReadData = r_mbox_data;
        default:     oReadData = '0;
      endcase
    end
  end

endmodule
